// File: rtl/axis_pkt_tx_if.sv
// Command and byte-stream bundle for the packet transmitter.
// master = transmitter side, slave = command source / stream sink.
interface axis_pkt_tx_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_len;
  logic [7:0] cmd_seed;
  logic       cmd_mode;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;

  modport master (
    input  cmd_valid, cmd_len, cmd_seed, cmd_mode, tx_ready,
    output cmd_ready, tx_data, tx_valid, tx_last
  );

  modport slave (
    output cmd_valid, cmd_len, cmd_seed, cmd_mode, tx_ready,
    input  cmd_ready, tx_data, tx_valid, tx_last
  );
endinterface

// File: rtl/axis_pkt_tx.sv
// Packet transmitter: accepts a length/seed/mode command and emits a framed
// pattern packet under valid/ready backpressure, then idles GAP_CYCLES cycles.
//
// state | meaning
// IDLE  | cmd_ready raised, waiting for a command
// SEND  | presenting packet bytes, beat counter holds bytes remaining
// GAP   | enforced idle after a packet, gap timer counting down
module axis_pkt_tx #(
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  axis_pkt_tx_if.master bus,
  output logic          busy_o,
  output logic          pkt_done_o,
  output logic [15:0]   pkt_cnt_o
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  localparam logic [7:0] GapLoad = 8'(GAP_CYCLES);
  localparam bit         GapNone = (GAP_CYCLES == 0);

  state_e      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic [7:0]  gap_q, gap_d;
  logic        mode_q, mode_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        tx_valid_q, tx_valid_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_last_q, tx_last_d;
  logic        pkt_done_q, pkt_done_d;
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  function automatic logic [7:0] next_byte(input logic [7:0] d, input logic lfsr);
    return lfsr ? {d[6:0], d[7] ^ d[5] ^ d[4] ^ d[3]} : d + 8'd1;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    mode_d      = mode_q;
    cmd_ready_d = cmd_ready_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    tx_last_d   = tx_last_q;
    pkt_done_d  = 1'b0;
    pkt_cnt_d   = pkt_cnt_q;

    case (state_q)
      IDLE: begin
        if (!cmd_ready_q) begin
          cmd_ready_d = 1'b1;
        end else if (bus.cmd_valid) begin
          state_d     = SEND;
          cmd_ready_d = 1'b0;
          mode_d      = bus.cmd_mode;
          cnt_d       = (bus.cmd_len == 8'd0) ? 9'd256 : {1'b0, bus.cmd_len};
          tx_valid_d  = 1'b1;
          // An all-zero LFSR would lock up, so a zero seed starts at 01.
          tx_data_d   = (bus.cmd_mode && bus.cmd_seed == 8'h00) ? 8'h01 : bus.cmd_seed;
          tx_last_d   = (bus.cmd_len == 8'd1);
        end
      end
      SEND: begin
        if (tx_valid_q && bus.tx_ready) begin
          if (cnt_q == 9'd1) begin
            tx_valid_d = 1'b0;
            tx_last_d  = 1'b0;
            tx_data_d  = 8'h00;
            pkt_done_d = 1'b1;
            pkt_cnt_d  = pkt_cnt_q + 16'd1;
            if (GapNone) begin
              state_d     = IDLE;
              cmd_ready_d = 1'b1;
            end else begin
              state_d = GAP;
              gap_d   = GapLoad;
            end
          end else begin
            cnt_d     = cnt_q - 9'd1;
            tx_data_d = next_byte(tx_data_q, mode_q);
            tx_last_d = (cnt_q == 9'd2);
          end
        end
      end
      GAP: begin
        if (gap_q <= 8'd1) begin
          state_d     = IDLE;
          cmd_ready_d = 1'b1;
          gap_d       = 8'd0;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 9'd0;
      gap_q       <= 8'd0;
      mode_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_last_q   <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      mode_q      <= mode_d;
      cmd_ready_q <= cmd_ready_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      tx_last_q   <= tx_last_d;
      pkt_done_q  <= pkt_done_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_last   = tx_last_q;
  assign busy_o        = (state_q != IDLE);
  assign pkt_done_o    = pkt_done_q;
  assign pkt_cnt_o     = pkt_cnt_q;

endmodule

// File: tb/tb_axis_pkt_tx.sv
// Directed bench for axis_pkt_tx: one instance with a 2-cycle gap, one with none.
module tb_axis_pkt_tx;
  logic        clk = 1'b0;
  logic        reset;
  logic        busy_a, pkt_done_a, busy_b, pkt_done_b;
  logic [15:0] pkt_cnt_a, pkt_cnt_b;
  int          n_vec = 0;
  int          n_err = 0;

  axis_pkt_tx_if bus_a ();
  axis_pkt_tx_if bus_b ();

  axis_pkt_tx #(.GAP_CYCLES(2)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a),
    .busy_o(busy_a), .pkt_done_o(pkt_done_a), .pkt_cnt_o(pkt_cnt_a)
  );

  axis_pkt_tx #(.GAP_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b),
    .busy_o(busy_b), .pkt_done_o(pkt_done_b), .pkt_cnt_o(pkt_cnt_b)
  );

  always #5 clk = ~clk;

  // Issue one command on instance A; returns at the falling edge after the accept edge.
  task automatic cmd_a(input logic [7:0] len, input logic [7:0] seed, input logic mode);
    int k = 0;
    while (bus_a.cmd_ready !== 1'b1 && k < 20) begin @(negedge clk); k++; end
    n_vec++;
    if (bus_a.cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL cmd_accept_wait: cmd_ready=%b, want 1", bus_a.cmd_ready);
    end
    bus_a.cmd_len = len; bus_a.cmd_seed = seed; bus_a.cmd_mode = mode; bus_a.cmd_valid = 1'b1;
    @(negedge clk);
    // Scramble the command fields; the packet must ignore them.
    bus_a.cmd_valid = 1'b0; bus_a.cmd_len = 8'd1; bus_a.cmd_seed = 8'hAA; bus_a.cmd_mode = ~mode;
  endtask

  task automatic wait_idle_a();
    int k = 0;
    while (busy_a === 1'b1 && k < 20) begin @(negedge clk); k++; end
    n_vec++;
    if (busy_a !== 1'b0) begin n_err++; $display("FAIL idle_wait: busy=%b, want 0", busy_a); end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (bus_a.cmd_ready !== 1'b0 || bus_a.tx_valid !== 1'b0 || bus_a.tx_data !== 8'h00 ||
        bus_a.tx_last !== 1'b0 || busy_a !== 1'b0 || pkt_done_a !== 1'b0 || pkt_cnt_a !== 16'd0) begin
      n_err++;
      $display("FAIL reset_values: rdy=%b vld=%b data=%h last=%b busy=%b done=%b cnt=%0d, want all 0",
               bus_a.cmd_ready, bus_a.tx_valid, bus_a.tx_data, bus_a.tx_last, busy_a, pkt_done_a, pkt_cnt_a);
    end
    reset = 1'b1;
    n_vec++;
    if (bus_a.cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset_release_rdy: cmd_ready=%b, want 0", bus_a.cmd_ready); end
    @(negedge clk);
    n_vec++;
    if (bus_a.cmd_ready !== 1'b1 || bus_b.cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL first_edge_rdy: a=%b b=%b, want 1 1", bus_a.cmd_ready, bus_b.cmd_ready);
    end
  endtask

  task automatic test_incr();
    logic [7:0] exp_b [4];
    int busy_cyc = 0, done_n = 0, k = 0;
    exp_b = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    bus_a.tx_ready = 1'b1;
    cmd_a(8'd4, 8'hFE, 1'b0);
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (bus_a.tx_valid !== 1'b1 || bus_a.tx_data !== exp_b[i] || bus_a.tx_last !== (i == 3)) begin
        n_err++;
        $display("FAIL incr_beat%0d: vld=%b data=%h last=%b, want 1 %h %b",
                 i, bus_a.tx_valid, bus_a.tx_data, bus_a.tx_last, exp_b[i], (i == 3));
      end
      busy_cyc += int'(busy_a);
      done_n += int'(pkt_done_a);
      @(negedge clk);
    end
    n_vec++;
    if (pkt_done_a !== 1'b1 || pkt_cnt_a !== 16'd1 || bus_a.tx_valid !== 1'b0 || bus_a.tx_data !== 8'h00) begin
      n_err++;
      $display("FAIL incr_done: done=%b cnt=%0d vld=%b data=%h, want 1 1 0 00",
               pkt_done_a, pkt_cnt_a, bus_a.tx_valid, bus_a.tx_data);
    end
    while (busy_a === 1'b1 && k < 20) begin
      busy_cyc++; done_n += int'(pkt_done_a); k++;
      @(negedge clk);
    end
    n_vec++;
    if (busy_cyc != 6) begin n_err++; $display("FAIL incr_busy_cycles: got %0d, want 6", busy_cyc); end
    n_vec++;
    if (done_n != 1) begin n_err++; $display("FAIL incr_done_pulses: got %0d, want 1", done_n); end
    n_vec++;
    if (bus_a.cmd_ready !== 1'b1) begin n_err++; $display("FAIL incr_rdy_after_gap: cmd_ready=%b, want 1", bus_a.cmd_ready); end
  endtask

  task automatic test_backpressure();
    bus_a.tx_ready = 1'b1;
    cmd_a(8'd3, 8'h10, 1'b0);
    n_vec++;
    if (bus_a.tx_valid !== 1'b1 || bus_a.tx_data !== 8'h10 || bus_a.tx_last !== 1'b0) begin
      n_err++; $display("FAIL bp_beat0: vld=%b data=%h last=%b, want 1 10 0", bus_a.tx_valid, bus_a.tx_data, bus_a.tx_last);
    end
    @(negedge clk);
    bus_a.tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (bus_a.tx_valid !== 1'b1 || bus_a.tx_data !== 8'h11 || bus_a.tx_last !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold%0d: vld=%b data=%h last=%b, want 1 11 0", i, bus_a.tx_valid, bus_a.tx_data, bus_a.tx_last);
      end
      if (i < 3) @(negedge clk);
    end
    bus_a.tx_ready = 1'b1;
    @(negedge clk);
    n_vec++;
    if (bus_a.tx_valid !== 1'b1 || bus_a.tx_data !== 8'h12 || bus_a.tx_last !== 1'b1) begin
      n_err++; $display("FAIL bp_beat2: vld=%b data=%h last=%b, want 1 12 1", bus_a.tx_valid, bus_a.tx_data, bus_a.tx_last);
    end
    @(negedge clk);
    n_vec++;
    if (bus_a.tx_valid !== 1'b0 || pkt_done_a !== 1'b1 || pkt_cnt_a !== 16'd2) begin
      n_err++; $display("FAIL bp_done: vld=%b done=%b cnt=%0d, want 0 1 2", bus_a.tx_valid, pkt_done_a, pkt_cnt_a);
    end
    wait_idle_a();
  endtask

  task automatic test_len0();
    int bad = 0;
    bus_a.tx_ready = 1'b1;
    cmd_a(8'd0, 8'h00, 1'b0);
    for (int i = 0; i < 256; i++) begin
      n_vec++;
      if (bus_a.tx_valid !== 1'b1 || bus_a.tx_data !== 8'(i) || bus_a.tx_last !== (i == 255)) begin
        n_err++; bad++;
        if (bad < 5)
          $display("FAIL len0_beat%0d: vld=%b data=%h last=%b, want 1 %h %b",
                   i, bus_a.tx_valid, bus_a.tx_data, bus_a.tx_last, 8'(i), (i == 255));
      end
      @(negedge clk);
    end
    n_vec++;
    if (bus_a.tx_valid !== 1'b0 || pkt_done_a !== 1'b1 || pkt_cnt_a !== 16'd3) begin
      n_err++; $display("FAIL len0_end: vld=%b done=%b cnt=%0d, want 0 1 3", bus_a.tx_valid, pkt_done_a, pkt_cnt_a);
    end
    wait_idle_a();
  endtask

  task automatic test_lfsr();
    logic [7:0] exp_b [5];
    exp_b = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    bus_a.tx_ready = 1'b1;
    cmd_a(8'd5, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (bus_a.tx_valid !== 1'b1 || bus_a.tx_data !== exp_b[i] || bus_a.tx_last !== (i == 4)) begin
        n_err++;
        $display("FAIL lfsr_beat%0d: vld=%b data=%h last=%b, want 1 %h %b",
                 i, bus_a.tx_valid, bus_a.tx_data, bus_a.tx_last, exp_b[i], (i == 4));
      end
      @(negedge clk);
    end
    n_vec++;
    if (bus_a.tx_valid !== 1'b0 || pkt_cnt_a !== 16'd4) begin
      n_err++; $display("FAIL lfsr_end: vld=%b cnt=%0d, want 0 4", bus_a.tx_valid, pkt_cnt_a);
    end
    wait_idle_a();
  endtask

  task automatic test_back_to_back();
    int beats = 0, low = 0, k = 0;
    bus_a.tx_ready = 1'b1;
    bus_a.cmd_len = 8'd2; bus_a.cmd_seed = 8'h20; bus_a.cmd_mode = 1'b0; bus_a.cmd_valid = 1'b1;
    while (beats < 4 && k < 40) begin
      if (bus_a.tx_valid === 1'b1) begin
        n_vec++;
        if (bus_a.tx_data !== ((beats % 2 == 0) ? 8'h20 : 8'h21)) begin
          n_err++; $display("FAIL b2b_gap2_beat%0d: data=%h, want %h", beats, bus_a.tx_data, (beats % 2 == 0) ? 8'h20 : 8'h21);
        end
        beats++;
      end else if (beats == 2) begin
        low++;
      end
      k++;
      @(negedge clk);
    end
    bus_a.cmd_valid = 1'b0;
    n_vec++;
    if (beats != 4) begin n_err++; $display("FAIL b2b_gap2_beats: got %0d, want 4", beats); end
    n_vec++;
    if (low != 3) begin n_err++; $display("FAIL b2b_gap2_low: got %0d cycles, want 3", low); end
    n_vec++;
    if (pkt_cnt_a !== 16'd6) begin n_err++; $display("FAIL b2b_gap2_cnt: got %0d, want 6", pkt_cnt_a); end
    wait_idle_a();
  endtask

  task automatic test_gap0();
    int beats = 0, low = 0, k = 0;
    bus_b.tx_ready = 1'b1;
    bus_b.cmd_len = 8'd2; bus_b.cmd_seed = 8'h30; bus_b.cmd_mode = 1'b0; bus_b.cmd_valid = 1'b1;
    while (beats < 4 && k < 40) begin
      if (bus_b.tx_valid === 1'b1) begin
        n_vec++;
        if (bus_b.tx_data !== ((beats % 2 == 0) ? 8'h30 : 8'h31) || bus_b.tx_last !== (beats % 2 == 1)) begin
          n_err++;
          $display("FAIL b2b_gap0_beat%0d: data=%h last=%b, want %h %b", beats, bus_b.tx_data, bus_b.tx_last,
                   (beats % 2 == 0) ? 8'h30 : 8'h31, (beats % 2 == 1));
        end
        beats++;
      end else if (beats == 2) begin
        low++;
      end
      k++;
      @(negedge clk);
    end
    bus_b.cmd_valid = 1'b0;
    n_vec++;
    if (beats != 4 || low != 1) begin
      n_err++; $display("FAIL b2b_gap0_low: beats=%0d low=%0d, want 4 1", beats, low);
    end
    n_vec++;
    if (pkt_cnt_b !== 16'd2 || busy_b !== 1'b0 || bus_b.cmd_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_gap0_end: cnt=%0d busy=%b rdy=%b, want 2 0 1", pkt_cnt_b, busy_b, bus_b.cmd_ready);
    end
  endtask

  task automatic test_reset_mid();
    int done_n = 0;
    bus_a.tx_ready = 1'b1;
    cmd_a(8'd8, 8'h40, 1'b0);
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus_a.tx_data !== 8'h43 || bus_a.tx_valid !== 1'b1) begin
      n_err++; $display("FAIL rmid_pre: data=%h vld=%b, want 43 1", bus_a.tx_data, bus_a.tx_valid);
    end
    reset = 1'b0;
    #1;
    n_vec++;
    if (bus_a.tx_valid !== 1'b0 || bus_a.tx_last !== 1'b0 || bus_a.tx_data !== 8'h00 || pkt_cnt_a !== 16'd0 ||
        busy_a !== 1'b0 || bus_a.cmd_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_async: vld=%b last=%b data=%h cnt=%0d busy=%b rdy=%b, want all 0",
               bus_a.tx_valid, bus_a.tx_last, bus_a.tx_data, pkt_cnt_a, busy_a, bus_a.cmd_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      done_n += int'(pkt_done_a);
    end
    reset = 1'b1;
    @(negedge clk);
    done_n += int'(pkt_done_a);
    n_vec++;
    if (done_n != 0) begin n_err++; $display("FAIL rmid_no_done: pulses=%0d, want 0", done_n); end
    n_vec++;
    if (bus_a.cmd_ready !== 1'b1) begin n_err++; $display("FAIL rmid_rdy: cmd_ready=%b, want 1", bus_a.cmd_ready); end
    cmd_a(8'd2, 8'h00, 1'b1);
    n_vec++;
    if (bus_a.tx_valid !== 1'b1 || bus_a.tx_data !== 8'h01 || bus_a.tx_last !== 1'b0) begin
      n_err++; $display("FAIL rmid_new0: vld=%b data=%h last=%b, want 1 01 0", bus_a.tx_valid, bus_a.tx_data, bus_a.tx_last);
    end
    @(negedge clk);
    n_vec++;
    if (bus_a.tx_valid !== 1'b1 || bus_a.tx_data !== 8'h02 || bus_a.tx_last !== 1'b1) begin
      n_err++; $display("FAIL rmid_new1: vld=%b data=%h last=%b, want 1 02 1", bus_a.tx_valid, bus_a.tx_data, bus_a.tx_last);
    end
    @(negedge clk);
    n_vec++;
    if (pkt_done_a !== 1'b1 || pkt_cnt_a !== 16'd1) begin
      n_err++; $display("FAIL rmid_new_done: done=%b cnt=%0d, want 1 1", pkt_done_a, pkt_cnt_a);
    end
    wait_idle_a();
  endtask

  initial begin
    reset = 1'b0;
    bus_a.cmd_valid = 1'b0; bus_a.cmd_len = 8'd0; bus_a.cmd_seed = 8'd0; bus_a.cmd_mode = 1'b0; bus_a.tx_ready = 1'b0;
    bus_b.cmd_valid = 1'b0; bus_b.cmd_len = 8'd0; bus_b.cmd_seed = 8'd0; bus_b.cmd_mode = 1'b0; bus_b.tx_ready = 1'b0;
    test_reset();
    test_incr();
    test_backpressure();
    test_len0();
    test_lfsr();
    test_back_to_back();
    test_gap0();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
